// File: rtl/sdram_axi_arbiter.sv
// sdram_axi_arbiter: two-master AXI4 arbiter in front of the SDRAM AXI slave.
// Grants one complete burst at a time (address, all data beats, response).
// Master 0 is instruction fetch, master 1 is load/store.
// Optional build macro SDRAM_ARB_FIXED_PRIO_EN: when defined, master 0 always
// wins simultaneous requests; otherwise the preference alternates per burst.
//
// Handshake semantics: a beat transfers on a rising clock edge where the
// sender's valid and the receiver's ready are both 1. Once the FSM leaves IDLE
// the selected channel is a pure combinational pass-through between in[gnt]
// and out. Every other channel has its valid and ready held at 0.
module sdram_axi_arbiter #(
  parameter  int ID_W   = 4,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  // master 0
  input  logic              in0_awvalid,
  input  logic [ADDR_W-1:0] in0_awaddr,
  input  logic [ID_W-1:0]   in0_awid,
  input  logic [7:0]        in0_awlen,
  input  logic [2:0]        in0_awsize,
  input  logic [1:0]        in0_awburst,
  output logic              in0_awready,
  input  logic              in0_wvalid,
  input  logic [DATA_W-1:0] in0_wdata,
  input  logic [STRB_W-1:0] in0_wstrb,
  input  logic              in0_wlast,
  output logic              in0_wready,
  output logic              in0_bvalid,
  output logic [1:0]        in0_bresp,
  output logic [ID_W-1:0]   in0_bid,
  input  logic              in0_bready,
  input  logic              in0_arvalid,
  input  logic [ADDR_W-1:0] in0_araddr,
  input  logic [ID_W-1:0]   in0_arid,
  input  logic [7:0]        in0_arlen,
  input  logic [2:0]        in0_arsize,
  input  logic [1:0]        in0_arburst,
  output logic              in0_arready,
  output logic              in0_rvalid,
  output logic [DATA_W-1:0] in0_rdata,
  output logic [1:0]        in0_rresp,
  output logic              in0_rlast,
  output logic [ID_W-1:0]   in0_rid,
  input  logic              in0_rready,
  // master 1
  input  logic              in1_awvalid,
  input  logic [ADDR_W-1:0] in1_awaddr,
  input  logic [ID_W-1:0]   in1_awid,
  input  logic [7:0]        in1_awlen,
  input  logic [2:0]        in1_awsize,
  input  logic [1:0]        in1_awburst,
  output logic              in1_awready,
  input  logic              in1_wvalid,
  input  logic [DATA_W-1:0] in1_wdata,
  input  logic [STRB_W-1:0] in1_wstrb,
  input  logic              in1_wlast,
  output logic              in1_wready,
  output logic              in1_bvalid,
  output logic [1:0]        in1_bresp,
  output logic [ID_W-1:0]   in1_bid,
  input  logic              in1_bready,
  input  logic              in1_arvalid,
  input  logic [ADDR_W-1:0] in1_araddr,
  input  logic [ID_W-1:0]   in1_arid,
  input  logic [7:0]        in1_arlen,
  input  logic [2:0]        in1_arsize,
  input  logic [1:0]        in1_arburst,
  output logic              in1_arready,
  output logic              in1_rvalid,
  output logic [DATA_W-1:0] in1_rdata,
  output logic [1:0]        in1_rresp,
  output logic              in1_rlast,
  output logic [ID_W-1:0]   in1_rid,
  input  logic              in1_rready,
  // downstream SDRAM slave
  output logic              out_awvalid,
  output logic [ADDR_W-1:0] out_awaddr,
  output logic [ID_W-1:0]   out_awid,
  output logic [7:0]        out_awlen,
  output logic [2:0]        out_awsize,
  output logic [1:0]        out_awburst,
  input  logic              out_awready,
  output logic              out_wvalid,
  output logic [DATA_W-1:0] out_wdata,
  output logic [STRB_W-1:0] out_wstrb,
  output logic              out_wlast,
  input  logic              out_wready,
  input  logic              out_bvalid,
  input  logic [1:0]        out_bresp,
  input  logic [ID_W-1:0]   out_bid,
  output logic              out_bready,
  output logic              out_arvalid,
  output logic [ADDR_W-1:0] out_araddr,
  output logic [ID_W-1:0]   out_arid,
  output logic [7:0]        out_arlen,
  output logic [2:0]        out_arsize,
  output logic [1:0]        out_arburst,
  input  logic              out_arready,
  input  logic              out_rvalid,
  input  logic [DATA_W-1:0] out_rdata,
  input  logic [1:0]        out_rresp,
  input  logic              out_rlast,
  input  logic [ID_W-1:0]   out_rid,
  output logic              out_rready,
  // FSM state for observation
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RADDR = 3'd4,
    RDATA = 3'd5
  } state_t;

  state_t state, state_n;
  logic   gnt, gnt_n;
  logic   rr, rr_n, rr_upd;
  logic   win;

  logic req0, req1;
  logic sel_awvalid, sel_wvalid, sel_wlast, sel_bready, sel_arvalid, sel_rready;
  logic g_awready, g_wready, g_bvalid, g_arready, g_rvalid;

  assign req0      = in0_awvalid | in0_arvalid;
  assign req1      = in1_awvalid | in1_arvalid;
  assign dbg_state = state;

  // Control signals of the granted master
  assign sel_awvalid = gnt ? in1_awvalid : in0_awvalid;
  assign sel_wvalid  = gnt ? in1_wvalid  : in0_wvalid;
  assign sel_wlast   = gnt ? in1_wlast   : in0_wlast;
  assign sel_bready  = gnt ? in1_bready  : in0_bready;
  assign sel_arvalid = gnt ? in1_arvalid : in0_arvalid;
  assign sel_rready  = gnt ? in1_rready  : in0_rready;

  // Downstream payload always follows the granted master
  assign out_awaddr  = gnt ? in1_awaddr  : in0_awaddr;
  assign out_awid    = gnt ? in1_awid    : in0_awid;
  assign out_awlen   = gnt ? in1_awlen   : in0_awlen;
  assign out_awsize  = gnt ? in1_awsize  : in0_awsize;
  assign out_awburst = gnt ? in1_awburst : in0_awburst;
  assign out_wdata   = gnt ? in1_wdata   : in0_wdata;
  assign out_wstrb   = gnt ? in1_wstrb   : in0_wstrb;
  assign out_wlast   = gnt ? in1_wlast   : in0_wlast;
  assign out_araddr  = gnt ? in1_araddr  : in0_araddr;
  assign out_arid    = gnt ? in1_arid    : in0_arid;
  assign out_arlen   = gnt ? in1_arlen   : in0_arlen;
  assign out_arsize  = gnt ? in1_arsize  : in0_arsize;
  assign out_arburst = gnt ? in1_arburst : in0_arburst;

  // State, grant and preference registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      rr    <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      rr    <= rr_n;
    end
  end

  // Next-state: arbitrate in IDLE, then follow the burst to its response
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    rr_upd  = rr;
    win     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          win     = (req0 & req1) ? rr : req1;
          gnt_n   = win;
          state_n = (win ? in1_awvalid : in0_awvalid) ? WADDR : RADDR;
        end
      end
      WADDR: if (sel_awvalid & out_awready) state_n = WDATA;
      WDATA: if (sel_wvalid & out_wready & sel_wlast) state_n = WRESP;
      WRESP: begin
        if (out_bvalid & sel_bready) begin
          state_n = IDLE;
          rr_upd  = ~gnt;
        end
      end
      RADDR: if (sel_arvalid & out_arready) state_n = RDATA;
      RDATA: begin
        if (out_rvalid & sel_rready & out_rlast) begin
          state_n = IDLE;
          rr_upd  = ~gnt;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    rr_n = 1'b0;
`else
    rr_n = rr_upd;
`endif
  end

  // Outputs: open only the active channel, demux responses to the granted master
  always_comb begin
    out_awvalid = 1'b0;
    out_wvalid  = 1'b0;
    out_bready  = 1'b0;
    out_arvalid = 1'b0;
    out_rready  = 1'b0;
    g_awready   = 1'b0;
    g_wready    = 1'b0;
    g_bvalid    = 1'b0;
    g_arready   = 1'b0;
    g_rvalid    = 1'b0;
    case (state)
      WADDR: begin
        out_awvalid = sel_awvalid;
        g_awready   = out_awready;
      end
      WDATA: begin
        out_wvalid = sel_wvalid;
        g_wready   = out_wready;
      end
      WRESP: begin
        out_bready = sel_bready;
        g_bvalid   = out_bvalid;
      end
      RADDR: begin
        out_arvalid = sel_arvalid;
        g_arready   = out_arready;
      end
      RDATA: begin
        out_rready = sel_rready;
        g_rvalid   = out_rvalid;
      end
      default: ;
    endcase

    in0_awready = ~gnt & g_awready;
    in0_wready  = ~gnt & g_wready;
    in0_bvalid  = ~gnt & g_bvalid;
    in0_arready = ~gnt & g_arready;
    in0_rvalid  = ~gnt & g_rvalid;
    in1_awready =  gnt & g_awready;
    in1_wready  =  gnt & g_wready;
    in1_bvalid  =  gnt & g_bvalid;
    in1_arready =  gnt & g_arready;
    in1_rvalid  =  gnt & g_rvalid;

    in0_bresp = gnt ? 2'b00 : out_bresp;
    in0_bid   = gnt ? '0 : out_bid;
    in0_rdata = gnt ? '0 : out_rdata;
    in0_rresp = gnt ? 2'b00 : out_rresp;
    in0_rlast = gnt ? 1'b0 : out_rlast;
    in0_rid   = gnt ? '0 : out_rid;
    in1_bresp = gnt ? out_bresp : 2'b00;
    in1_bid   = gnt ? out_bid : '0;
    in1_rdata = gnt ? out_rdata : '0;
    in1_rresp = gnt ? out_rresp : 2'b00;
    in1_rlast = gnt ? out_rlast : 1'b0;
    in1_rid   = gnt ? out_rid : '0;
  end

endmodule

// File: tb/tb_sdram_axi_arbiter.sv
// tb_sdram_axi_arbiter: directed bench for sdram_axi_arbiter. The bench plays
// both masters and the downstream SDRAM slave. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_sdram_axi_arbiter;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, STRB_W = DATA_W / 8;

  logic clock, reset;
  logic              in0_awvalid, in0_awready, in0_wvalid, in0_wlast, in0_wready;
  logic [ADDR_W-1:0] in0_awaddr, in0_araddr;
  logic [ID_W-1:0]   in0_awid, in0_bid, in0_arid, in0_rid;
  logic [7:0]        in0_awlen, in0_arlen;
  logic [2:0]        in0_awsize, in0_arsize;
  logic [1:0]        in0_awburst, in0_arburst, in0_bresp, in0_rresp;
  logic [DATA_W-1:0] in0_wdata, in0_rdata;
  logic [STRB_W-1:0] in0_wstrb;
  logic              in0_bvalid, in0_bready, in0_arvalid, in0_arready;
  logic              in0_rvalid, in0_rlast, in0_rready;
  logic              in1_awvalid, in1_awready, in1_wvalid, in1_wlast, in1_wready;
  logic [ADDR_W-1:0] in1_awaddr, in1_araddr;
  logic [ID_W-1:0]   in1_awid, in1_bid, in1_arid, in1_rid;
  logic [7:0]        in1_awlen, in1_arlen;
  logic [2:0]        in1_awsize, in1_arsize;
  logic [1:0]        in1_awburst, in1_arburst, in1_bresp, in1_rresp;
  logic [DATA_W-1:0] in1_wdata, in1_rdata;
  logic [STRB_W-1:0] in1_wstrb;
  logic              in1_bvalid, in1_bready, in1_arvalid, in1_arready;
  logic              in1_rvalid, in1_rlast, in1_rready;
  logic              out_awvalid, out_awready, out_wvalid, out_wlast, out_wready;
  logic [ADDR_W-1:0] out_awaddr, out_araddr;
  logic [ID_W-1:0]   out_awid, out_bid, out_arid, out_rid;
  logic [7:0]        out_awlen, out_arlen;
  logic [2:0]        out_awsize, out_arsize;
  logic [1:0]        out_awburst, out_arburst, out_bresp, out_rresp;
  logic [DATA_W-1:0] out_wdata, out_rdata;
  logic [STRB_W-1:0] out_wstrb;
  logic              out_bvalid, out_bready, out_arvalid, out_arready;
  logic              out_rvalid, out_rlast, out_rready;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  sdram_axi_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .in0_awvalid(in0_awvalid), .in0_awaddr(in0_awaddr), .in0_awid(in0_awid),
    .in0_awlen(in0_awlen), .in0_awsize(in0_awsize), .in0_awburst(in0_awburst),
    .in0_awready(in0_awready), .in0_wvalid(in0_wvalid), .in0_wdata(in0_wdata),
    .in0_wstrb(in0_wstrb), .in0_wlast(in0_wlast), .in0_wready(in0_wready),
    .in0_bvalid(in0_bvalid), .in0_bresp(in0_bresp), .in0_bid(in0_bid),
    .in0_bready(in0_bready), .in0_arvalid(in0_arvalid), .in0_araddr(in0_araddr),
    .in0_arid(in0_arid), .in0_arlen(in0_arlen), .in0_arsize(in0_arsize),
    .in0_arburst(in0_arburst), .in0_arready(in0_arready), .in0_rvalid(in0_rvalid),
    .in0_rdata(in0_rdata), .in0_rresp(in0_rresp), .in0_rlast(in0_rlast),
    .in0_rid(in0_rid), .in0_rready(in0_rready),
    .in1_awvalid(in1_awvalid), .in1_awaddr(in1_awaddr), .in1_awid(in1_awid),
    .in1_awlen(in1_awlen), .in1_awsize(in1_awsize), .in1_awburst(in1_awburst),
    .in1_awready(in1_awready), .in1_wvalid(in1_wvalid), .in1_wdata(in1_wdata),
    .in1_wstrb(in1_wstrb), .in1_wlast(in1_wlast), .in1_wready(in1_wready),
    .in1_bvalid(in1_bvalid), .in1_bresp(in1_bresp), .in1_bid(in1_bid),
    .in1_bready(in1_bready), .in1_arvalid(in1_arvalid), .in1_araddr(in1_araddr),
    .in1_arid(in1_arid), .in1_arlen(in1_arlen), .in1_arsize(in1_arsize),
    .in1_arburst(in1_arburst), .in1_arready(in1_arready), .in1_rvalid(in1_rvalid),
    .in1_rdata(in1_rdata), .in1_rresp(in1_rresp), .in1_rlast(in1_rlast),
    .in1_rid(in1_rid), .in1_rready(in1_rready),
    .out_awvalid(out_awvalid), .out_awaddr(out_awaddr), .out_awid(out_awid),
    .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
    .out_awready(out_awready), .out_wvalid(out_wvalid), .out_wdata(out_wdata),
    .out_wstrb(out_wstrb), .out_wlast(out_wlast), .out_wready(out_wready),
    .out_bvalid(out_bvalid), .out_bresp(out_bresp), .out_bid(out_bid),
    .out_bready(out_bready), .out_arvalid(out_arvalid), .out_araddr(out_araddr),
    .out_arid(out_arid), .out_arlen(out_arlen), .out_arsize(out_arsize),
    .out_arburst(out_arburst), .out_arready(out_arready), .out_rvalid(out_rvalid),
    .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast),
    .out_rid(out_rid), .out_rready(out_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    in0_awvalid = 0; in0_awaddr = '0; in0_awid = '0; in0_awlen = '0; in0_awsize = 3'd2; in0_awburst = 2'd1;
    in0_wvalid = 0; in0_wdata = '0; in0_wstrb = '0; in0_wlast = 0; in0_bready = 0;
    in0_arvalid = 0; in0_araddr = '0; in0_arid = '0; in0_arlen = '0; in0_arsize = 3'd2; in0_arburst = 2'd1;
    in0_rready = 0;
    in1_awvalid = 0; in1_awaddr = '0; in1_awid = '0; in1_awlen = '0; in1_awsize = 3'd2; in1_awburst = 2'd1;
    in1_wvalid = 0; in1_wdata = '0; in1_wstrb = '0; in1_wlast = 0; in1_bready = 0;
    in1_arvalid = 0; in1_araddr = '0; in1_arid = '0; in1_arlen = '0; in1_arsize = 3'd2; in1_arburst = 2'd1;
    in1_rready = 0;
    out_awready = 1; out_wready = 1; out_arready = 1;
    out_bvalid = 0; out_bresp = '0; out_bid = '0;
    out_rvalid = 0; out_rdata = '0; out_rresp = '0; out_rlast = 0; out_rid = '0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    clear_inputs();
    reset = 1;
    in0_arvalid = 1;
    in1_awvalid = 1;
    @(negedge clock);
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    checks++; if ({out_awvalid, out_wvalid, out_bready, out_arvalid, out_rready} !== 5'b0) begin
      errors++; $display("FAIL rst_out_vr: got %b exp 00000", {out_awvalid, out_wvalid, out_bready, out_arvalid, out_rready}); end
    checks++; if ({in0_awready, in0_wready, in0_bvalid, in0_arready, in0_rvalid,
                   in1_awready, in1_wready, in1_bvalid, in1_arready, in1_rvalid} !== 10'b0) begin
      errors++; $display("FAIL rst_in_vr: got %b exp 0", {in0_awready, in0_wready, in0_bvalid, in0_arready, in0_rvalid,
                   in1_awready, in1_wready, in1_bvalid, in1_arready, in1_rvalid}); end
    apply_reset();
  endtask

  task automatic test_single_read;
    logic exp_last;
    apply_reset();
    in1_arvalid = 1; in1_araddr = 32'hA000_0010; in1_arlen = 8'd3; in1_arid = 4'd5;
    @(negedge clock);
    checks++; if (out_arvalid !== 1'b0) begin errors++; $display("FAIL rd_idle_arvalid: got %b exp 0", out_arvalid); end
    checks++; if (in1_arready !== 1'b0) begin errors++; $display("FAIL rd_idle_arready: got %b exp 0", in1_arready); end
    tick();
    @(negedge clock);
    checks++; if (out_arvalid !== 1'b1) begin errors++; $display("FAIL rd_arvalid: got %b exp 1", out_arvalid); end
    checks++; if (out_araddr !== 32'hA000_0010) begin errors++; $display("FAIL rd_araddr: got %h exp a0000010", out_araddr); end
    checks++; if (out_arid !== 4'd5) begin errors++; $display("FAIL rd_arid: got %0d exp 5", out_arid); end
    checks++; if (out_arlen !== 8'd3) begin errors++; $display("FAIL rd_arlen: got %0d exp 3", out_arlen); end
    checks++; if (in1_arready !== 1'b1) begin errors++; $display("FAIL rd_arready: got %b exp 1", in1_arready); end
    checks++; if (in0_arready !== 1'b0) begin errors++; $display("FAIL rd_in0_arready: got %b exp 0", in0_arready); end
    tick();
    in1_arvalid = 0; in1_rready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_last = (i == 3);
      out_rvalid = 1; out_rdata = 32'h5000_0000 + i; out_rid = 4'd5; out_rlast = exp_last;
      @(negedge clock);
      checks++; if (in1_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid[%0d]: got %b exp 1", i, in1_rvalid); end
      checks++; if (in1_rdata !== 32'h5000_0000 + i) begin errors++; $display("FAIL rd_rdata[%0d]: got %h exp %h", i, in1_rdata, 32'h5000_0000 + i); end
      checks++; if (in1_rid !== 4'd5) begin errors++; $display("FAIL rd_rid[%0d]: got %0d exp 5", i, in1_rid); end
      checks++; if (in1_rlast !== exp_last) begin errors++; $display("FAIL rd_rlast[%0d]: got %b exp %b", i, in1_rlast, exp_last); end
      checks++; if (in0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_in0_rvalid[%0d]: got %b exp 0", i, in0_rvalid); end
      checks++; if (out_rready !== 1'b1) begin errors++; $display("FAIL rd_out_rready[%0d]: got %b exp 1", i, out_rready); end
      tick();
    end
    out_rvalid = 0; out_rlast = 0;
    @(negedge clock);
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rd_end_state: got %0d exp 0", dbg_state); end
  endtask

  task automatic test_simultaneous;
    apply_reset();
    in0_arvalid = 1; in0_arid = 4'd1; in0_arlen = 8'd0; in0_rready = 1;
    in1_awvalid = 1; in1_awid = 4'd9; in1_awlen = 8'd0; in1_awaddr = 32'h0000_0040; in1_bready = 1;
    tick();
    @(negedge clock);
    checks++; if (out_arvalid !== 1'b1) begin errors++; $display("FAIL sim_arvalid: got %b exp 1", out_arvalid); end
    checks++; if (out_awvalid !== 1'b0) begin errors++; $display("FAIL sim_awvalid_busy: got %b exp 0", out_awvalid); end
    checks++; if (in1_awready !== 1'b0) begin errors++; $display("FAIL sim_in1_awready_busy: got %b exp 0", in1_awready); end
    tick();
    in0_arvalid = 0;
    out_rvalid = 1; out_rlast = 1; out_rid = 4'd1; out_rdata = 32'h1234_5678;
    @(negedge clock);
    checks++; if (in0_rvalid !== 1'b1) begin errors++; $display("FAIL sim_in0_rvalid: got %b exp 1", in0_rvalid); end
    tick();
    out_rvalid = 0; out_rlast = 0;
    @(negedge clock);
    checks++; if (out_awvalid !== 1'b0) begin errors++; $display("FAIL sim_turn_t1: got %b exp 0", out_awvalid); end
    tick();
    @(negedge clock);
    checks++; if (out_awvalid !== 1'b1) begin errors++; $display("FAIL sim_turn_t2: got %b exp 1", out_awvalid); end
    checks++; if (out_awid !== 4'd9) begin errors++; $display("FAIL sim_awid: got %0d exp 9", out_awid); end
    checks++; if (in1_awready !== 1'b1) begin errors++; $display("FAIL sim_in1_awready: got %b exp 1", in1_awready); end
    tick();
    in1_awvalid = 0; in1_wvalid = 1; in1_wlast = 1; in1_wdata = 32'hCAFE_F00D; in1_wstrb = 4'hF;
    @(negedge clock);
    checks++; if (out_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL sim_wdata: got %h exp cafef00d", out_wdata); end
    tick();
    in1_wvalid = 0; in1_wlast = 0;
    out_bvalid = 1; out_bid = 4'd9; out_bresp = 2'd0;
    @(negedge clock);
    checks++; if (in1_bvalid !== 1'b1) begin errors++; $display("FAIL sim_in1_bvalid: got %b exp 1", in1_bvalid); end
    checks++; if (in1_bid !== 4'd9) begin errors++; $display("FAIL sim_in1_bid: got %0d exp 9", in1_bid); end
    checks++; if (in0_bvalid !== 1'b0) begin errors++; $display("FAIL sim_in0_bvalid: got %b exp 0", in0_bvalid); end
    tick();
    out_bvalid = 0;
    @(negedge clock);
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL sim_end_state: got %0d exp 0", dbg_state); end
  endtask

  task automatic test_round_robin;
    int rem0, rem1, got, g;
    logic [0:5] order;
    logic [0:5] exp_order;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_order = 6'b000111;
`else
    exp_order = 6'b010101;
`endif
    apply_reset();
    rem0 = 3; rem1 = 3; got = 0; order = '0;
    in0_rready = 1; in1_rready = 1;
    out_rvalid = 1; out_rlast = 1;
    in0_arvalid = 1; in1_arvalid = 1;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clock);
      g = -1;
      if (in0_arready) g = 0;
      else if (in1_arready) g = 1;
      if (g >= 0) begin
        order[got] = (g == 1);
        got++;
      end
      tick();
      if (g == 0) begin rem0--; if (rem0 == 0) in0_arvalid = 0; end
      if (g == 1) begin rem1--; if (rem1 == 0) in1_arvalid = 0; end
    end
    checks++; if (got !== 6) begin errors++; $display("FAIL rr_grant_count: got %0d exp 6", got); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (order[i] !== exp_order[i]) begin errors++; $display("FAIL rr_order[%0d]: got %b exp %b", i, order[i], exp_order[i]); end
    end
    in0_arvalid = 0; in1_arvalid = 0;
    repeat (2) tick();
    out_rvalid = 0; out_rlast = 0;
  endtask

  task automatic test_write_strobes;
    apply_reset();
    in0_awvalid = 1; in0_awaddr = 32'h0000_0100; in0_awid = 4'd3; in0_awlen = 8'd1; in0_bready = 1;
    tick();
    @(negedge clock);
    checks++; if (out_awvalid !== 1'b1) begin errors++; $display("FAIL wr_awvalid: got %b exp 1", out_awvalid); end
    checks++; if (out_awaddr !== 32'h0000_0100) begin errors++; $display("FAIL wr_awaddr: got %h exp 00000100", out_awaddr); end
    checks++; if (out_awlen !== 8'd1) begin errors++; $display("FAIL wr_awlen: got %0d exp 1", out_awlen); end
    tick();
    in0_awvalid = 0;
    out_wready = 0;
    in0_wvalid = 1; in0_wdata = 32'h1122_3344; in0_wstrb = 4'hF; in0_wlast = 0;
    @(negedge clock);
    checks++; if (in0_wready !== 1'b0) begin errors++; $display("FAIL wr_stall_wready: got %b exp 0", in0_wready); end
    checks++; if (out_wvalid !== 1'b1) begin errors++; $display("FAIL wr_stall_wvalid: got %b exp 1", out_wvalid); end
    tick();
    out_wready = 1;
    @(negedge clock);
    checks++; if (out_wdata !== 32'h1122_3344) begin errors++; $display("FAIL wr_wdata0: got %h exp 11223344", out_wdata); end
    checks++; if (out_wstrb !== 4'hF) begin errors++; $display("FAIL wr_wstrb0: got %h exp f", out_wstrb); end
    checks++; if (out_wlast !== 1'b0) begin errors++; $display("FAIL wr_wlast0: got %b exp 0", out_wlast); end
    checks++; if (in0_wready !== 1'b1) begin errors++; $display("FAIL wr_wready0: got %b exp 1", in0_wready); end
    tick();
    in0_wdata = 32'hAABB_CCDD; in0_wstrb = 4'h3; in0_wlast = 1;
    @(negedge clock);
    checks++; if (out_wdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL wr_wdata1: got %h exp aabbccdd", out_wdata); end
    checks++; if (out_wstrb !== 4'h3) begin errors++; $display("FAIL wr_wstrb1: got %h exp 3", out_wstrb); end
    checks++; if (out_wlast !== 1'b1) begin errors++; $display("FAIL wr_wlast1: got %b exp 1", out_wlast); end
    tick();
    in0_wvalid = 0; in0_wlast = 0;
    out_bvalid = 1; out_bresp = 2'd0; out_bid = 4'd3;
    @(negedge clock);
    checks++; if (in0_bvalid !== 1'b1) begin errors++; $display("FAIL wr_bvalid: got %b exp 1", in0_bvalid); end
    checks++; if (in0_bresp !== 2'd0) begin errors++; $display("FAIL wr_bresp: got %0d exp 0", in0_bresp); end
    checks++; if (in0_bid !== 4'd3) begin errors++; $display("FAIL wr_bid: got %0d exp 3", in0_bid); end
    checks++; if (out_bready !== 1'b1) begin errors++; $display("FAIL wr_bready: got %b exp 1", out_bready); end
    checks++; if (in1_bvalid !== 1'b0) begin errors++; $display("FAIL wr_in1_bvalid: got %b exp 0", in1_bvalid); end
    tick();
    out_bvalid = 0;
  endtask

  task automatic test_same_master_priority;
    apply_reset();
    in0_awvalid = 1; in0_awid = 4'd6; in0_awlen = 8'd0; in0_bready = 1;
    in0_arvalid = 1; in0_arid = 4'd7; in0_arlen = 8'd0; in0_rready = 1;
    tick();
    @(negedge clock);
    checks++; if (out_awvalid !== 1'b1) begin errors++; $display("FAIL pri_awvalid: got %b exp 1", out_awvalid); end
    checks++; if (out_arvalid !== 1'b0) begin errors++; $display("FAIL pri_arvalid_waddr: got %b exp 0", out_arvalid); end
    tick();
    in0_awvalid = 0; in0_wvalid = 1; in0_wlast = 1;
    @(negedge clock);
    checks++; if (out_arvalid !== 1'b0) begin errors++; $display("FAIL pri_arvalid_wdata: got %b exp 0", out_arvalid); end
    tick();
    in0_wvalid = 0; in0_wlast = 0; out_bvalid = 1; out_bid = 4'd6;
    @(negedge clock);
    checks++; if (out_arvalid !== 1'b0) begin errors++; $display("FAIL pri_arvalid_wresp: got %b exp 0", out_arvalid); end
    checks++; if (in0_arready !== 1'b0) begin errors++; $display("FAIL pri_arready_wresp: got %b exp 0", in0_arready); end
    tick();
    out_bvalid = 0;
    tick();
    @(negedge clock);
    checks++; if (out_arvalid !== 1'b1) begin errors++; $display("FAIL pri_arvalid_after: got %b exp 1", out_arvalid); end
    checks++; if (out_arid !== 4'd7) begin errors++; $display("FAIL pri_arid: got %0d exp 7", out_arid); end
    tick();
    in0_arvalid = 0; out_rvalid = 1; out_rlast = 1; out_rid = 4'd7;
    tick();
    out_rvalid = 0; out_rlast = 0;
    @(negedge clock);
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL pri_end_state: got %0d exp 0", dbg_state); end
  endtask

  task automatic test_mid_burst_reset;
    apply_reset();
    in1_arvalid = 1; in1_arlen = 8'd3; in1_arid = 4'd4; in1_rready = 1;
    tick();
    tick();
    in1_arvalid = 0;
    out_rvalid = 1; out_rid = 4'd4; out_rdata = 32'h0000_0001;
    tick();
    out_rdata = 32'h0000_0002;
    @(negedge clock);
    checks++; if (in1_rvalid !== 1'b1) begin errors++; $display("FAIL mbr_beat2_rvalid: got %b exp 1", in1_rvalid); end
    #1 reset = 1;
    #1;
    checks++; if (in1_rvalid !== 1'b0) begin errors++; $display("FAIL mbr_rvalid: got %b exp 0", in1_rvalid); end
    checks++; if (out_rready !== 1'b0) begin errors++; $display("FAIL mbr_rready: got %b exp 0", out_rready); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL mbr_state: got %0d exp 0", dbg_state); end
    @(posedge clock);
    #1 reset = 0;
    clear_inputs();
    in0_arvalid = 1; in0_arid = 4'd2; in0_arlen = 8'd0; in0_rready = 1;
    tick();
    @(negedge clock);
    checks++; if (out_arvalid !== 1'b1) begin errors++; $display("FAIL mbr_new_arvalid: got %b exp 1", out_arvalid); end
    checks++; if (out_arid !== 4'd2) begin errors++; $display("FAIL mbr_new_arid: got %0d exp 2", out_arid); end
    tick();
    in0_arvalid = 0; out_rvalid = 1; out_rlast = 1; out_rid = 4'd2; out_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    checks++; if (in0_rvalid !== 1'b1) begin errors++; $display("FAIL mbr_new_rvalid: got %b exp 1", in0_rvalid); end
    checks++; if (in0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mbr_new_rdata: got %h exp deadbeef", in0_rdata); end
    tick();
    out_rvalid = 0; out_rlast = 0;
    @(negedge clock);
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL mbr_end_state: got %0d exp 0", dbg_state); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_write_strobes();
    test_same_master_priority();
    test_mid_burst_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_axi_arbiter.md
# sdram_axi_arbiter

Two-master AXI4 arbiter in front of the SDRAM AXI slave (`sdram_top_axi`). It shares the single SDRAM port between the instruction-fetch master (`in0_*`) and the load/store master (`in1_*`). Arbitration is transaction-level: one complete burst is granted at a time, covering the address phase, all data beats and the response. The downstream `out_*` bundle connects directly to the `in_*` ports of `sdram_top_axi`.

## Interface
Parameters:
- `ID_W`, 4: AXI ID width, identical on all ports.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. `STRB_W` = `DATA_W`/8.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `inN_aw*`  (N=0,1): `awvalid` in 1, `awaddr` in ADDR_W, `awid` in ID_W, `awlen` in 8, `awsize` in 3, `awburst` in 2, `awready` out 1.
- `inN_w*`: `wvalid` in 1, `wdata` in DATA_W, `wstrb` in STRB_W, `wlast` in 1, `wready` out 1.
- `inN_b*`: `bvalid` out 1, `bresp` out 2, `bid` out ID_W, `bready` in 1.
- `inN_ar*`: `arvalid` in 1, `araddr` in ADDR_W, `arid` in ID_W, `arlen` in 8, `arsize` in 3, `arburst` in 2, `arready` out 1.
- `inN_r*`: `rvalid` out 1, `rdata` out DATA_W, `rresp` out 2, `rlast` out 1, `rid` out ID_W, `rready` in 1.
- `out_*`: the same five channels with directions mirrored, acting as master toward SDRAM.

## Operation
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA. Registers: `gnt` (1 bit, selected master), `rr` (1 bit, preferred master).
- **IDLE:** a master requests if `awvalid|arvalid`.
  - One requester: that master wins.
  - Both request: master `rr` wins.
  - Within the winning master, AW takes priority over AR.
  - On a win, `gnt` is latched and the FSM moves to WADDR or RADDR. No handshake completes in IDLE.
- **WADDR:** `out_aw*` = `in[gnt]_aw*`, and `in[gnt]_awready` = `out_awready`. On AW handshake, go to WDATA.
- **WDATA:** W channel passes through from `in[gnt]`. On a handshake with `wlast`=1, go to WRESP.
- **WRESP:** B channel is routed to `in[gnt]`. On `out_bvalid&out_bready`, go to IDLE and set `rr` = ~`gnt`.
- **RADDR / RDATA:** same pattern on AR, then R. Leave RDATA on a handshake with `rlast`=1, then set `rr` = ~`gnt`.
- IDs pass through unmodified. Routing uses `gnt` only, since exactly one transaction is outstanding.
- Non-granted master and idle channels:
  - All its ready and valid outputs are 0.
  - Its data, id and resp outputs are 0.
  - `out_*` payload follows `in[gnt]` even when the corresponding valid is 0.
- A beat count different from `awlen+1` is not checked; only `wlast` ends the write.

## Timing
- Reset values: state IDLE, `gnt`=0, `rr`=0, every valid and ready output 0.
- Reset is asynchronous. Asserting it mid-burst forces IDLE and drops all valids and readys in the same cycle. The downstream slave shares the same reset.
- Arbitration latency: request seen in IDLE at cycle t, `out_awvalid`/`out_arvalid` asserted at t+1.
- All channel paths after the grant are combinational; no added latency per beat.
- Turnaround: last B/R handshake at cycle t, IDLE at t+1, next grant visible at t+2.
- A valid dropped in IDLE before the grant registers has no effect (AXI forbids this; it is not checked).
- Requests that arrive while busy wait; their readys stay 0.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN`
  - Defined: `rr` is held at 0 permanently, so master 0 always wins simultaneous requests (fixed priority for instruction fetch).
  - Undefined: round-robin as described above.

## Test plan
- Single read: `in1` AR with addr 0xA000_0010, len 3, id 5 → `out_arvalid` one cycle later; 4 R beats reach `in1` with `rid`=5 and `rlast` on beat 4; `in0_rvalid` stays 0.
- Simultaneous: `in0` AR and `in1` AW in the same cycle after reset → `in0` granted first; after its `rlast`, `in1` AW is granted at +2 cycles.
- Round-robin: both masters issue 3 back-to-back single reads → grant order 0,1,0,1,0,1 (fixed-priority build: 0,0,0,1,1,1).
- Write with strobes: `in0` AW len 1, W beats 0x1122_3344/0xF and 0xAABB_CCDD/0x3 → same beats on `out_w*`; `in0_bvalid` asserted with `bresp`=0 and matching `bid`.
- Same-master priority: `in0` asserts AW and AR together → write completes through B before `out_arvalid` rises.
- Mid-burst reset: assert `reset` during the 2nd of 4 R beats → all valids and readys 0 in the same cycle; after release the FSM is IDLE and a new read completes normally.
